bcd_stopwatch: RTL and testbench

//  4-digit BCD MM:SS stopwatch built on an up-counting carry chain; the

---
 rtl/bcd_stopwatch_pkg.sv | 17 +
 rtl/bcd_stopwatch_upcounter.sv | 40 ++++
 rtl/bcd_stopwatch.sv | 112 +++++++++++
 tb/tb_bcd_stopwatch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_pkg.sv
// Shared constants and state encoding for the BCD MM:SS stopwatch.
package bcd_stopwatch_pkg;

  localparam int unsigned BCD_BIT_WIDTH = 4;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_ZERO  = 4'd0;
  localparam logic [BCD_BIT_WIDTH-1:0] INCREMENT = 4'd1;
  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StFull  = 2'd3
  } stw_state_e;

endpackage

// File: rtl/bcd_stopwatch_upcounter.sv
// One BCD digit of the up-counting carry chain: wraps at limit and emits carry.
module bcd_upcounter
  import bcd_stopwatch_pkg::*;
#(
  parameter int unsigned Width = BCD_BIT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             increase,
  input  logic [Width-1:0] limit,
  input  logic             clr,
  output logic [Width-1:0] value,
  output logic [Width-1:0] value_nxt,
  output logic             carry
);

  logic [Width-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = Width'(BCD_ZERO);
    end else if (increase) begin
      value_d = (value_q == limit) ? Width'(BCD_ZERO) : value_q + Width'(INCREMENT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= Width'(BCD_ZERO);
    end else begin
      value_q <= value_d;
    end
  end

  assign value     = value_q;
  assign value_nxt = value_d;
  assign carry     = increase && (value_q == limit);

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch top: run/pause/full FSM, digit chain, saturation and lap hold.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int unsigned BCD_W       = BCD_BIT_WIDTH,
  parameter int unsigned SEC1_LIMIT  = 5,
  parameter int unsigned MIN1_LIMIT  = 5,
  parameter int unsigned DIGIT_LIMIT = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             pb_start,
  input  logic             pb_lap,
  input  logic             pb_clr,
  output logic [4*BCD_W-1:0] count,
  output logic [4*BCD_W-1:0] disp,
  output logic             running,
  output logic             lap_hold,
  output logic             full
);

  // Digit order in every packed array: [3]=min1 [2]=min0 [1]=sec1 [0]=sec0.
  localparam logic [3:0][BCD_W-1:0] Limits = {BCD_W'(MIN1_LIMIT), BCD_W'(DIGIT_LIMIT),
                                              BCD_W'(SEC1_LIMIT), BCD_W'(DIGIT_LIMIT)};

  stw_state_e state_q, state_d;
  logic [3:0][BCD_W-1:0] val, val_nxt;
  logic [3:0] inc, carry;
  logic [4*BCD_W-1:0] lap_q, lap_d;
  logic lap_hold_q, lap_hold_d;
  logic at_max, count_en, lap_set;

  assign at_max = (val == Limits);
  // Saturate at 59:59: the tick that reaches FULL must not wrap the chain.
  assign count_en = (state_q == StRun) && tick && !at_max && !pb_clr;

  always_comb begin
    inc = {carry[2:0], count_en};
  end

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_upcounter #(
      .Width(BCD_W)
    ) u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .increase (inc[i]),
      .limit    (Limits[i]),
      .clr      (pb_clr),
      .value    (val[i]),
      .value_nxt(val_nxt[i]),
      .carry    (carry[i])
    );
  end

  always_comb begin
    state_d = state_q;
    if (pb_clr) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (pb_start) state_d = StRun;
        StRun: begin
          if (tick && at_max) begin
            state_d = StFull;
          end else if (pb_start) begin
            state_d = StPause;
          end
        end
        StPause: if (pb_start) state_d = StRun;
        StFull:  state_d = StFull;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    lap_hold_d = lap_hold_q;
    lap_d      = lap_q;
    lap_set    = DISABLED;
    if (pb_clr || state_d == StFull) begin
      lap_hold_d = DISABLED;
    end else if (pb_lap && (state_q == StRun || state_q == StPause)) begin
      lap_hold_d = !lap_hold_q;
      lap_set    = !lap_hold_q;
    end
    // Latch the post-tick value so a same-cycle increment is captured.
    if (lap_set) begin
      lap_d = val_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lap_q      <= '0;
      lap_hold_q <= DISABLED;
    end else begin
      state_q    <= state_d;
      lap_q      <= lap_d;
      lap_hold_q <= lap_hold_d;
    end
  end

  assign count    = val;
  assign disp     = lap_hold_q ? lap_q : val;
  assign running  = (state_q == StRun);
  assign lap_hold = lap_hold_q;
  assign full     = (state_q == StFull);

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed self-checking bench for bcd_stopwatch.
module tb_bcd_stopwatch;

  logic        clk = 1'b0;
  logic        rst_n, tick, pb_start, pb_lap, pb_clr;
  logic [15:0] count, disp;
  logic        running, lap_hold, full;
  int          n_checks = 0;
  int          n_fail = 0;

  bcd_stopwatch dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .pb_start(pb_start),
    .pb_lap  (pb_lap),
    .pb_clr  (pb_clr),
    .count   (count),
    .disp    (disp),
    .running (running),
    .lap_hold(lap_hold),
    .full    (full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic press_start();
    pb_start = 1'b1;
    step();
    pb_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (count !== 16'h0000) begin
      n_fail++; $display("FAIL reset_count got=%h exp=0000", count);
    end
    n_checks++;
    if (disp !== 16'h0000) begin
      n_fail++; $display("FAIL reset_disp got=%h exp=0000", disp);
    end
    n_checks++;
    if ({running, lap_hold, full} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {running, lap_hold, full});
    end
  endtask

  task automatic test_count();
    do_reset();
    press_start();
    ticks(3);
    n_checks++;
    if (count !== 16'h0003 || running !== 1'b1) begin
      n_fail++; $display("FAIL count3 got=%h run=%b exp=0003 run=1", count, running);
    end
    repeat (4) step();
    n_checks++;
    if (count !== 16'h0003) begin
      n_fail++; $display("FAIL count_idle_cycles got=%h exp=0003", count);
    end
  endtask

  task automatic test_carry();
    do_reset();
    press_start();
    ticks(59);
    n_checks++;
    if (count !== 16'h0059) begin
      n_fail++; $display("FAIL carry_pre59 got=%h exp=0059", count);
    end
    ticks(1);
    n_checks++;
    if (count !== 16'h0100) begin
      n_fail++; $display("FAIL carry_0100 got=%h exp=0100", count);
    end
    ticks(539);
    n_checks++;
    if (count !== 16'h0959) begin
      n_fail++; $display("FAIL carry_pre959 got=%h exp=0959", count);
    end
    ticks(1);
    n_checks++;
    if (count !== 16'h1000) begin
      n_fail++; $display("FAIL carry_1000 got=%h exp=1000", count);
    end
  endtask

  task automatic test_full();
    do_reset();
    press_start();
    ticks(3598);
    pb_lap = 1'b1;
    step();
    pb_lap = 1'b0;
    n_checks++;
    if (count !== 16'h5958 || lap_hold !== 1'b1 || disp !== 16'h5958) begin
      n_fail++; $display("FAIL full_pre got=%h lap=%b disp=%h exp=5958 1 5958",
                         count, lap_hold, disp);
    end
    ticks(1);
    n_checks++;
    if (count !== 16'h5959 || disp !== 16'h5958 || full !== 1'b0) begin
      n_fail++; $display("FAIL full_5959 got=%h disp=%h full=%b exp=5959 5958 0",
                         count, disp, full);
    end
    ticks(1);
    n_checks++;
    if (count !== 16'h5959 || full !== 1'b1 || running !== 1'b0) begin
      n_fail++; $display("FAIL full_enter got=%h full=%b run=%b exp=5959 1 0",
                         count, full, running);
    end
    n_checks++;
    if (lap_hold !== 1'b0 || disp !== 16'h5959) begin
      n_fail++; $display("FAIL full_lap_release lap=%b disp=%h exp=0 5959", lap_hold, disp);
    end
    tick = 1'b1; pb_start = 1'b1; pb_lap = 1'b1;
    step();
    tick = 1'b0; pb_start = 1'b0; pb_lap = 1'b0;
    ticks(2);
    n_checks++;
    if (count !== 16'h5959 || full !== 1'b1 || lap_hold !== 1'b0) begin
      n_fail++; $display("FAIL full_hold got=%h full=%b lap=%b exp=5959 1 0",
                         count, full, lap_hold);
    end
    pb_clr = 1'b1;
    step();
    pb_clr = 1'b0;
    ticks(2);
    n_checks++;
    if (count !== 16'h0000 || {running, full} !== 2'b00) begin
      n_fail++; $display("FAIL full_clr got=%h run_full=%b exp=0000 00", count, {running, full});
    end
  endtask

  task automatic test_lap();
    do_reset();
    press_start();
    ticks(10);
    pb_lap = 1'b1;
    step();
    pb_lap = 1'b0;
    ticks(5);
    n_checks++;
    if (disp !== 16'h0010 || count !== 16'h0015 || lap_hold !== 1'b1) begin
      n_fail++; $display("FAIL lap_frozen disp=%h cnt=%h lap=%b exp=0010 0015 1",
                         disp, count, lap_hold);
    end
    pb_lap = 1'b1;
    step();
    pb_lap = 1'b0;
    n_checks++;
    if (disp !== 16'h0015 || lap_hold !== 1'b0) begin
      n_fail++; $display("FAIL lap_release disp=%h lap=%b exp=0015 0", disp, lap_hold);
    end
    pb_lap = 1'b1; tick = 1'b1;
    step();
    pb_lap = 1'b0; tick = 1'b0;
    ticks(2);
    n_checks++;
    if (disp !== 16'h0016 || count !== 16'h0018) begin
      n_fail++; $display("FAIL lap_post_tick disp=%h cnt=%h exp=0016 0018", disp, count);
    end
    pb_clr = 1'b1; pb_lap = 1'b1; tick = 1'b1;
    step();
    pb_clr = 1'b0; pb_lap = 1'b0; tick = 1'b0;
    n_checks++;
    if (lap_hold !== 1'b0 || disp !== 16'h0000 || running !== 1'b0) begin
      n_fail++; $display("FAIL lap_clr lap=%b disp=%h run=%b exp=0 0000 0", lap_hold, disp, running);
    end
    pb_lap = 1'b1;
    step();
    pb_lap = 1'b0;
    n_checks++;
    if (lap_hold !== 1'b0) begin
      n_fail++; $display("FAIL lap_idle_ignored got=%b exp=0", lap_hold);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    press_start();
    ticks(7);
    tick = 1'b1; pb_start = 1'b1;
    step();
    tick = 1'b0; pb_start = 1'b0;
    n_checks++;
    if (count !== 16'h0008 || running !== 1'b0) begin
      n_fail++; $display("FAIL pause_same_cycle got=%h run=%b exp=0008 0", count, running);
    end
    ticks(1);
    n_checks++;
    if (count !== 16'h0008) begin
      n_fail++; $display("FAIL pause_tick_ignored got=%h exp=0008", count);
    end
    press_start();
    ticks(1);
    n_checks++;
    if (count !== 16'h0009 || running !== 1'b1) begin
      n_fail++; $display("FAIL resume got=%h run=%b exp=0009 1", count, running);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_start();
    ticks(753);
    n_checks++;
    if (count !== 16'h1233) begin
      n_fail++; $display("FAIL mid_pre got=%h exp=1233", count);
    end
    ticks(1);
    rst_n = 1'b0; tick = 1'b1;
    step();
    rst_n = 1'b1; tick = 1'b0;
    n_checks++;
    if (count !== 16'h0000 || running !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got=%h run=%b exp=0000 0", count, running);
    end
    ticks(2);
    n_checks++;
    if (count !== 16'h0000) begin
      n_fail++; $display("FAIL mid_idle got=%h exp=0000", count);
    end
    press_start();
    ticks(4);
    pb_clr = 1'b1; pb_start = 1'b1; tick = 1'b1;
    step();
    pb_clr = 1'b0; pb_start = 1'b0; tick = 1'b0;
    ticks(1);
    n_checks++;
    if (count !== 16'h0000 || running !== 1'b0) begin
      n_fail++; $display("FAIL clr_over_start got=%h run=%b exp=0000 0", count, running);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; pb_start = 1'b0; pb_lap = 1'b0; pb_clr = 1'b0;
    step();
    test_reset();
    test_count();
    test_carry();
    test_full();
    test_lap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
